// File: rtl/tpu_pkg.sv
// tpu_pkg: definitions shared by the systolic array blocks.
//   seq_state_t        : sequencer FSM state encoding
//   K_DEF/N_DEF/Q_DEF  : default array size, word width and fractional bits
//   word_t             : signed data word shared with the PE/MAC
package tpu_pkg;

  localparam int K_DEF = 4;
  localparam int N_DEF = 32;
  localparam int Q_DEF = 10;

  typedef logic signed [N_DEF-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: host command, operand buffer and grid-edge signals of
// the systolic sequencer.
//   start/len              host command (host -> sequencer)
//   busy/done              host status (sequencer -> host)
//   rd_en/rd_addr          operand buffer read request (sequencer -> buffers)
//   a_rd_data/b_rd_data    operand buffer read data (buffers -> sequencer)
//   pe_clr/pe_en           grid accumulator clear and global enable
//   x_edge/y_edge          west/north grid edge operands
// Modport slave is the sequencer side; master is the surrounding system.
interface systolic_sequencer_if
  import tpu_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int N     = N_DEF,
  parameter int LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LEN_W-1:0] rd_addr;
  logic [K*N-1:0]   a_rd_data;
  logic [K*N-1:0]   b_rd_data;
  logic             pe_clr;
  logic             pe_en;
  logic [K*N-1:0]   x_edge;
  logic [K*N-1:0]   y_edge;

  modport slave (
    input  start, len, a_rd_data, b_rd_data,
    output busy, done, rd_en, rd_addr, pe_clr, pe_en, x_edge, y_edge
  );

  modport master (
    output start, len, a_rd_data, b_rd_data,
    input  busy, done, rd_en, rd_addr, pe_clr, pe_en, x_edge, y_edge
  );

endinterface

// File: rtl/skew_buffer.sv
// skew_buffer: triangular delay line feeding one edge of the systolic grid.
// Lane i delays its slice by i cycles, so lane 0 is a direct (gated) path.
// Slices arriving with vld low are replaced by zero before entering the lane,
// so invalid cycles reach the grid as harmless zero operands.
//   clk, rst : clock, asynchronous active-high reset (clears all lanes)
//   vld      : input slices valid this cycle
//   din      : K packed N-bit slices, slice i for lane i
//   dout     : K packed N-bit slices, lane i delayed by i cycles
module skew_buffer
  import tpu_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vld,
  input  logic [K*N-1:0] din,
  output logic [K*N-1:0] dout
);

  for (genvar i = 0; i < K; i++) begin : g_lane
    logic signed [N-1:0] lane_in;

    assign lane_in = vld ? din[i*N +: N] : '0;

    if (i == 0) begin : g_pass
      assign dout[N-1:0] = lane_in;
    end else begin : g_dly
      logic signed [N-1:0] dly_p [i];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int m = 0; m < i; m++) dly_p[m] <= '0;
        end else begin
          dly_p[0] <= lane_in;
          for (int m = 1; m < i; m++) dly_p[m] <= dly_p[m-1];
        end
      end

      assign dout[i*N +: N] = dly_p[i-1];
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: runs one C = A*B pass on a KxK systolic grid.
// Clears the grid, reads column k of A and row k of B for k = 0..len-1,
// skews them onto the west/north edges, keeps the grid enabled until the
// last product has been accumulated plus MAC_LAT drain cycles, then pulses
// done. Operands pass through bit-exact; no arithmetic is done here.
//   clk      : clock
//   rst      : asynchronous active-high reset; aborts a pass without done
//   bus      : systolic_sequencer_if.slave (host command/status, operand
//              buffer read port, grid clear/enable and edge operands)
module systolic_sequencer
  import tpu_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int N       = N_DEF,
  parameter int Q       = Q_DEF,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  systolic_sequencer_if.slave bus
);

  // Q is only meaningful to the MACs; reject a format that cannot exist.
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("systolic_sequencer: Q must lie in [0, N-1]");
  end
  if (MAC_LAT < 1) begin : g_bad_mac_lat
    $error("systolic_sequencer: MAC_LAT must be at least 1");
  end

  // Must hold len + 2K - 2 for the largest len without wrapping.
  localparam int CNT_W = LEN_W + $clog2(2*K) + 1;

  seq_state_t       state, state_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] feed_last;
  logic             vld_p1;

  // FEED runs len + 2K - 1 cycles: counter values 0 .. len + 2K - 2.
  assign feed_last = CNT_W'(len_q) + CNT_W'(2*K - 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      len_q  <= '0;
      cnt    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      len_q  <= len_nxt;
      cnt    <= cnt_nxt;
      vld_p1 <= bus.rd_en;
    end
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    cnt_nxt     = cnt;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.pe_clr  = 1'b0;
    bus.pe_en   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          len_nxt   = bus.len;
          cnt_nxt   = '0;
          state_nxt = S_CLEAR;
        end
      end

      S_CLEAR: begin
        bus.busy   = 1'b1;
        bus.pe_clr = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = (len_q == '0) ? S_DONE : S_FEED;
      end

      S_FEED: begin
        bus.busy = 1'b1;
        // First read data reaches the edges one cycle after FEED begins.
        bus.pe_en = (cnt != '0);
        if (cnt < CNT_W'(len_q)) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = cnt[LEN_W-1:0];
        end
        if (cnt == feed_last) begin
          cnt_nxt   = '0;
          state_nxt = S_DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_DRAIN: begin
        bus.busy  = 1'b1;
        bus.pe_en = 1'b1;
        if (cnt == CNT_W'(MAC_LAT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- p1: buffer read data valid; skew onto the grid edges ----
  skew_buffer #(.K(K), .N(N)) u_skew_a (
    .clk  (clk),
    .rst  (rst),
    .vld  (vld_p1),
    .din  (bus.a_rd_data),
    .dout (bus.x_edge)
  );

  skew_buffer #(.K(K), .N(N)) u_skew_b (
    .clk  (clk),
    .rst  (rst),
    .vld  (vld_p1),
    .din  (bus.b_rd_data),
    .dout (bus.y_edge)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
  import tpu_pkg::*;

  localparam int K       = 4;
  localparam int N       = 32;
  localparam int Q       = 10;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_sequencer_if #(.K(K), .N(N), .LEN_W(LEN_W)) bus ();

  systolic_sequencer #(.K(K), .N(N), .Q(Q), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Operand buffers: A[i][k] and B[k][j], one-cycle read latency.
  logic signed [N-1:0] amem [K][256];
  logic signed [N-1:0] bmem [256][K];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      for (int i = 0; i < K; i++) begin
        bus.a_rd_data[i*N +: N] <= amem[i][bus.rd_addr];
        bus.b_rd_data[i*N +: N] <= bmem[bus.rd_addr][i];
      end
    end
  end

  // Behavioural PE grid: x flows east, y flows south, acc += (x*y) >>> Q.
  longint              acc [K][K];
  logic signed [N-1:0] px  [K][K];
  logic signed [N-1:0] py  [K][K];
  logic signed [N-1:0] gx, gy;

  always @(posedge clk) begin
    if (bus.pe_clr) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          acc[i][j] = 0;
          px[i][j]  = '0;
          py[i][j]  = '0;
        end
    end else if (bus.pe_en) begin
      for (int i = K-1; i >= 0; i--)
        for (int j = K-1; j >= 0; j--) begin
          if (j == 0) gx = bus.x_edge[i*N +: N];
          else        gx = px[i][j-1];
          if (i == 0) gy = bus.y_edge[j*N +: N];
          else        gy = py[i-1][j];
          acc[i][j] = acc[i][j] + ((longint'(gx) * longint'(gy)) >>> Q);
          px[i][j]  = gx;
          py[i][j]  = gy;
        end
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-pass observations; cycle numbers count from the edge sampling start.
  int cur_len, clr_cyc, done_cyc, pe_first, pe_last, rd_cnt, addr_bad, data_bad;
  int busy1, busy_done;
  int xf [K];
  int xl [K];
  int xcnt [K];

  // Called in cycle 1 of a pass; returns in the done cycle (or after a bound).
  task automatic observe();
    logic signed [N-1:0] xe, ye, xv, yv;
    int k;
    clr_cyc = -1; done_cyc = -1; pe_first = -1; pe_last = -1;
    rd_cnt = 0; addr_bad = 0; data_bad = 0; busy1 = -1; busy_done = -1;
    for (int i = 0; i < K; i++) begin
      xf[i] = -1; xl[i] = -1; xcnt[i] = 0;
    end
    for (int c = 1; c <= 600; c++) begin
      if (c == 1) busy1 = int'(bus.busy);
      if (bus.pe_clr && clr_cyc < 0) clr_cyc = c;
      if (bus.rd_en) begin
        rd_cnt++;
        if (int'(bus.rd_addr) != c - 2) addr_bad++;
      end
      if (bus.pe_en) begin
        if (pe_first < 0) pe_first = c;
        pe_last = c;
      end
      for (int i = 0; i < K; i++) begin
        k = c - 3 - i;
        if (k >= 0 && k < cur_len) begin
          xe = amem[i][k];
          ye = bmem[k][i];
        end else begin
          xe = '0;
          ye = '0;
        end
        xv = bus.x_edge[i*N +: N];
        yv = bus.y_edge[i*N +: N];
        if (xv !== xe) data_bad++;
        if (yv !== ye) data_bad++;
        if (xv != '0) begin
          if (xf[i] < 0) xf[i] = c;
          xl[i] = c;
          xcnt[i]++;
        end
      end
      if (bus.done) begin
        done_cyc  = c;
        busy_done = int'(bus.busy);
        return;
      end
      tick();
    end
  endtask

  task automatic run_pass(input int l, input bit hold);
    bus.len   = LEN_W'(l);
    bus.start = 1'b1;
    cur_len   = l;
    tick();
    if (!hold) bus.start = 1'b0;
    observe();
  endtask

  task automatic fill_ident();
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < K; i++) begin
        amem[i][k] = (i == k) ? 32'sd1024 : 32'sd0;
        bmem[k][i] = N'(k*4 + i);
      end
  endtask

  function automatic int acc_ident_bad(input int rows);
    int bad = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (acc[i][j] != ((i < rows) ? longint'(i*4 + j) : 64'sd0)) bad++;
    return bad;
  endfunction

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_busy"},    bus.busy,    0);
    chk({pfx, "_done"},    bus.done,    0);
    chk({pfx, "_rd_en"},   bus.rd_en,   0);
    chk({pfx, "_rd_addr"}, bus.rd_addr, 0);
    chk({pfx, "_pe_clr"},  bus.pe_clr,  0);
    chk({pfx, "_pe_en"},   bus.pe_en,   0);
    chk({pfx, "_x_zero"},  (bus.x_edge == '0), 1);
    chk({pfx, "_y_zero"},  (bus.y_edge == '0), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.start = 1'b0;
    bus.len   = '0;
    rst       = 1'b1;
    fill_ident();
    #2;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Identity A (1.0 = 1024), B[k][j] = 4k+j, len = 4.
    run_pass(4, 1'b0);
    chk("id_clear_cycle", clr_cyc,   1);
    chk("id_busy_c1",     busy1,     1);
    chk("id_done_cycle",  done_cyc,  14);
    chk("id_busy_done",   busy_done, 0);
    chk("id_pe_first",    pe_first,  3);
    chk("id_pe_last",     pe_last,   13);
    chk("id_rd_count",    rd_cnt,    4);
    chk("id_rd_addr_bad", addr_bad,  0);
    chk("id_edge_bad",    data_bad,  0);
    chk("id_acc_bad",     acc_ident_bad(4), 0);
    chk("id_acc33",       acc[3][3], 15);
    tick();
    chk("id_done_pulse",  bus.done,  0);

    // len = 0: clear then done, no reads, no enable.
    run_pass(0, 1'b0);
    chk("z_clear_cycle", clr_cyc,  1);
    chk("z_done_cycle",  done_cyc, 2);
    chk("z_rd_count",    rd_cnt,   0);
    chk("z_pe_first",    pe_first, -1);
    tick();

    // start held high: one pass per IDLE visit, len re-captured.
    run_pass(2, 1'b1);
    chk("hold1_done_cycle", done_cyc, 12);
    chk("hold1_rd_count",   rd_cnt,   2);
    chk("hold1_clear",      clr_cyc,  1);
    bus.len = LEN_W'(3);
    cur_len = 3;
    tick();
    chk("hold_idle_busy",   bus.busy,   0);
    chk("hold_idle_clr",    bus.pe_clr, 0);
    tick();
    observe();
    bus.start = 1'b0;
    chk("hold2_clear",      clr_cyc,  1);
    chk("hold2_done_cycle", done_cyc, 13);
    chk("hold2_rd_count",   rd_cnt,   3);
    chk("hold2_edge_bad",   data_bad, 0);
    chk("hold2_acc_bad",    acc_ident_bad(3), 0);
    tick();

    // Reset at cycle 6 of a len = 8 pass, then a clean pass.
    bus.len   = LEN_W'(8);
    cur_len   = 8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("abort_pre_pe_en", bus.pe_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("abort");
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_pass(4, 1'b0);
    chk("post_done_cycle", done_cyc, 14);
    chk("post_acc_bad",    acc_ident_bad(4), 0);
    tick();

    // len = 1, A = 2.0, B = 3.0 everywhere: every acc = 6.0.
    for (int i = 0; i < K; i++) begin
      amem[i][0] = 32'sd2048;
      bmem[0][i] = 32'sd3072;
    end
    run_pass(1, 1'b0);
    chk("l1_done_cycle", done_cyc, 11);
    chk("l1_x3_first",   xf[3],    6);
    chk("l1_x3_last",    xl[3],    6);
    chk("l1_x3_count",   xcnt[3],  1);
    chk("l1_edge_bad",   data_bad, 0);
    seen = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (acc[i][j] != 6144) seen++;
    chk("l1_acc_bad", seen, 0);
    tick();

    // len = 5 random non-zero operands: edge windows 3+i .. 7+i.
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < K; i++) begin
        amem[i][k] = N'($urandom | 1);
        bmem[k][i] = N'($urandom | 1);
      end
    run_pass(5, 1'b0);
    chk("r5_done_cycle", done_cyc, 15);
    chk("r5_edge_bad",   data_bad, 0);
    for (int i = 0; i < K; i++) begin
      chk($sformatf("r5_x%0d_first", i), xf[i],   3 + i);
      chk($sformatf("r5_x%0d_last", i),  xl[i],   7 + i);
      chk($sformatf("r5_x%0d_count", i), xcnt[i], 5);
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequences one matrix-multiply pass on the K×K systolic grid of `processing_element` instances: C = A·B with inner dimension `len`. It clears the grid's accumulators, reads one column of A and one row of B per cycle from the operand buffers, skews them onto the array's west/north edges, holds the grid enable for exactly the required window plus MAC drain, and then pulses `done`. It sits between the host command interface and the PE grid; results are read directly from the grid's `acc_sum` outputs once `done` has pulsed.

## Interface
- `K`, default 4: array dimension (rows = cols = K).
- `N`, default 32: data word width, signed fixed point.
- `Q`, default 10: fractional bits; passed through only, no arithmetic here.
- `LEN_W`, default 8: width of `len` and of the buffer address.
- `MAC_LAT`, default 1: cycles from the last enabled product sample to a settled `acc_sum`.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  LEN_W  inner dimension; captured on accepted `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of the pass.
- `rd_en`  out  1  operand buffer read strobe.
- `rd_addr`  out  LEN_W  k index; selects column k of A and row k of B.
- `a_rd_data`  in  K*N  A[0..K-1][k]; row i in slice i; valid 1 cycle after `rd_en`.
- `b_rd_data`  in  K*N  B[k][0..K-1]; column j in slice j; same latency.
- `pe_clr`  out  1  accumulator clear to the grid, OR-ed into the PE `rst`.
- `pe_en`  out  1  global grid enable.
- `x_edge`  out  K*N  west-edge inputs; slice i drives `x_in` of PE(i,0).
- `y_edge`  out  K*N  north-edge inputs; slice j drives `y_in` of PE(0,j).

## Operation
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: `start`=1 captures `len` and moves to CLEAR. A `start` seen in any other state is ignored; there is no queueing.
- CLEAR: one cycle, `pe_clr`=1. Then go to FEED, or go to DONE directly if the captured `len`=0 (no reads, `pe_en` never asserted).
- FEED:
  - `rd_en`=1 with `rd_addr`=0,1,…,len-1 over the first `len` FEED cycles.
  - Returned data enters a triangular skew buffer. Row slice i is delayed i extra cycles; column slice j is delayed j extra cycles.
  - Edge slices carrying no valid data are driven to 0, so zero products are harmless to the accumulation.
- FEED lasts `len`+2K-1 cycles. DRAIN lasts MAC_LAT cycles with `pe_en`=1 and all edges zero.
- DONE: `done`=1 for one cycle, `busy`=0 in the same cycle, then return to IDLE.
- No arithmetic is done here. Operands pass bit-exact; overflow handling belongs to the MAC.

## Timing
- Let cycle 0 be the edge that samples `start`=1 in IDLE.
  - Cycle 1: CLEAR, `busy`=1.
  - FEED starts at cycle 2; `rd_addr`=k at cycle 2+k; data returns at 3+k.
  - `x_edge[i]` = A[i][k] at cycle 3+k+i; `y_edge[j]` = B[k][j] at cycle 3+k+j.
  - PE(i,j) therefore sees its pair at cycle 3+k+i+j. The last pair reaches PE(K-1,K-1) at cycle `len`+2K.
- `pe_en`=1 from cycle 3 through cycle `len`+2K+MAC_LAT inclusive.
- `done` pulses at cycle `len`+2K+MAC_LAT+1. Total latency from start to `done` is `len`+2K+MAC_LAT+1 cycles.
- Back-to-back: `start` may be sampled in the cycle after `done` (IDLE).
- Reset values, asynchronous: state=IDLE, and `busy`, `done`, `rd_en`, `rd_addr`, `pe_clr`, `pe_en`, `x_edge`, `y_edge` all 0. Skew registers are 0.
- Reset mid-pass aborts immediately with no `done`. Grid contents are undefined until the next CLEAR.
- `len` at its maximum (2^LEN_W-1): counters must not wrap. The FEED counter is LEN_W+1 bits wide or wider, enough to hold `len`+2K-1.

## Structure
- Shared package `tpu_pkg`:
  - the state enum `seq_state_t`;
  - the default `K`/`N`/`Q` constants;
  - a `word_t` typedef (signed [N-1:0]), shared with the PE/MAC.
- Sub-module `skew_buffer #(K, N)`, instantiated twice (A rows, B columns).
  - Lane i is an i-deep shift register; a load-valid bit zeroes the input when invalid.
- The FSM and counters stay in `systolic_sequencer`.

## Test plan
- K=4, len=4, A=identity (Q-scaled 1024), B[k][j]=k*4+j. Required: `done` at cycle 4+8+1+1=14, and every PE(i,j) `acc_sum` = B[i][j] after the MAC's Q-shift.
- len=0 `start`. Required: CLEAR at cycle 1, `done` at cycle 2, `rd_en` and `pe_en` never high.
- `start` held high through a whole pass. Required: exactly one pass per IDLE visit; the second starts at the cycle after `done`, and `len` is re-captured.
- Assert `rst` at cycle 6 of a len=8 pass. Required: all outputs 0 in the same cycle, no `done`, and a following pass gives correct results.
- len=1, A column all 2.0, B row all 3.0. Required: every `acc_sum`=6.0 (6144), and `x_edge[3]` nonzero only at cycle 6.
- Edge monitor: `x_edge[i]` nonzero only in cycles 3+i…2+i+len for random non-zero operands, len=5.
